// File: rtl/serial_adder_nbit.sv
// serial_adder_nbit
//   Bit-serial WIDTH-bit adder. Operands are shifted through one full-adder
//   cell LSB-first and the carry is kept in a flip-flop. A start/busy/done
//   handshake wraps the datapath. Results are held in output registers until
//   the next operation completes.
//
//   Optional feature: define SERIAL_ADDER_OVF_EN to add the Ovf port, which
//   reports two's-complement overflow of the held result.
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request, sampled only in IDLE or DONE
//   A, B   addends, sampled with an accepted start
//   Cin    carry-in, sampled with an accepted start
//   busy   high while an addition is in progress (RUN)
//   done   one-cycle pulse; S/Cout(/Ovf) were just updated
//   S      registered sum
//   Cout   registered carry-out of bit WIDTH-1
//   Ovf    registered signed overflow (SERIAL_ADDER_OVF_EN only)
module serial_adder_nbit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic             c_q;
  logic [CW-1:0]    cnt_q;

  logic             accept, last, s_bit, c_nxt;
  logic [WIDTH-1:0] sum_full;

  // start is only honoured outside RUN, so an in-flight operation is never
  // disturbed and back-to-back requests are taken from DONE.
  assign accept   = start && (state_q != RUN);
  assign last     = (cnt_q == CW'(WIDTH - 1));
  assign s_bit    = a_sh[0] ^ b_sh[0] ^ c_q;
  assign c_nxt    = (a_sh[0] & b_sh[0]) | (a_sh[0] & c_q) | (b_sh[0] & c_q);
  // Sum as it will stand once the current bit is shifted in; on the last
  // RUN cycle this is the finished result.
  assign sum_full = {s_bit, sum_sh[WIDTH-1:1]};

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      c_q    <= 1'b0;
      cnt_q  <= '0;
      S      <= '0;
      Cout   <= 1'b0;
    end else if (accept) begin
      a_sh   <= A;
      b_sh   <= B;
      sum_sh <= '0;
      c_q    <= Cin;
      cnt_q  <= '0;
    end else if (state_q == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      sum_sh <= sum_full;
      c_q    <= c_nxt;
      // Counter parks at WIDTH-1; it is cleared again on the next accept.
      if (!last) cnt_q <= cnt_q + CW'(1);
      if (last) begin
        S    <= sum_full;
        Cout <= c_nxt;
      end
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  // On the last bit c_q is the carry into the MSB; overflow is that carry
  // differing from the carry out of the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        Ovf <= 1'b0;
    else if (!accept && state_q == RUN && last) Ovf <= c_q ^ c_nxt;
  end
`endif

endmodule

// File: tb/tb_serial_adder_nbit.sv
module tb_serial_adder_nbit;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic         Cin = 1'b0;
  logic         busy, done, Cout;
  logic [W-1:0] S;
`ifdef SERIAL_ADDER_OVF_EN
  logic         Ovf;
`endif

  int n_run = 0, n_fail = 0;

  // scoreboard copy of the held result (from expectations, never the DUT)
  logic [W-1:0] hold_s = '0;
  logic         hold_c = 1'b0;

  always #5 clk = ~clk;

  serial_adder_nbit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Cin(Cin),
    .busy(busy), .done(done), .S(S), .Cout(Cout)
`ifdef SERIAL_ADDER_OVF_EN
    , .Ovf(Ovf)
`endif
  );

  typedef struct {
    logic [W-1:0] a, b;
    logic         cin;
    logic [W-1:0] s;
    logic         c, o;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain wide addition; overflow from the sign rule
  // (same-sign operands producing a result of the other sign).
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] a, b, input logic cin);
    logic [W:0] sum;
    logic       ovf;
    sum = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
    ovf = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
    return {ovf, sum};
  endfunction

  // One operation: accept, then check busy/done on every edge up to the
  // result, S/Cout held until then, and the final result. inject>=0 pulses
  // start with A=B=0x11 after that many RUN edges.
  task automatic run_op(input logic [W-1:0] a, b, input logic cin, input int inject,
                        input string nm, input logic [W-1:0] es, input logic ec, input logic eo);
    int bad;
    bad = 0;
    @(negedge clk);
    A = a; B = b; Cin = cin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
    if (!busy || done) bad++;
    for (int i = 1; i <= W; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (i < W) begin
        if (!busy || done || S !== hold_s || Cout !== hold_c) bad++;
      end else if (busy || !done) bad++;
      if (i == inject) begin
        start = 1'b1; A = 8'h11; B = 8'h11;
      end
    end
    chk({nm, " timing"}, bad, 0);
    chk({nm, " S"}, S, es);
    chk({nm, " Cout"}, Cout, ec);
`ifdef SERIAL_ADDER_OVF_EN
    chk({nm, " Ovf"}, Ovf, eo);
`else
    if (eo === 1'bx) $display("note: unexpected X expectation");
`endif
    hold_s = es;
    hold_c = ec;
  endtask

  initial begin
    vec_t         vt[6];
    logic [W+1:0] r;
    logic [W-1:0] ra, rb;
    logic         rc;
    int           bad;

    vt[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
    vt[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vt[2] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
    vt[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vt[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vt[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};

    // reset state
    #12;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst S", S, 0);
    chk("rst Cout", Cout, 0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("rst Ovf", Ovf, 0);
`endif
    @(negedge clk) rst_n = 1'b1;

    // directed table
    foreach (vt[i])
      run_op(vt[i].a, vt[i].b, vt[i].cin, -1, $sformatf("vec%0d", i), vt[i].s, vt[i].c, vt[i].o);

    // start pulsed mid-RUN is ignored; no extra done afterwards
    run_op(8'h5A, 8'h3C, 1'b0, 3, "ignore", 8'h96, 1'b0, 1'b1);
    bad = 0;
    for (int i = 0; i < W + 2; i++) begin
      @(posedge clk); #1;
      if (done || busy || S !== 8'h96) bad++;
    end
    chk("ignore extra", bad, 0);

    // start held high: back-to-back results every W+1 cycles
    @(negedge clk);
    A = 8'h01; B = 8'h02; Cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    A = 8'h10; B = 8'h20;
    bad = 0;
    for (int i = 1; i <= 2*W + 1; i++) begin
      logic ed;
      @(posedge clk); #1;
      ed = (i == W) || (i == 2*W + 1);
      if (done !== ed || busy !== !ed) bad++;
      if (i == W) chk("b2b S0", S, 8'h03);
      if (i == W + 1) start = 1'b0;
      if (i == 2*W + 1) chk("b2b S1", S, 8'h30);
    end
    chk("b2b timing", bad, 0);
    hold_s = 8'h30; hold_c = 1'b0;
    @(posedge clk); #1;

    // reset mid-RUN after a prior 0x96 result
    run_op(8'h5A, 8'h3C, 1'b0, -1, "pre-rst", 8'h96, 1'b0, 1'b1);
    @(negedge clk);
    A = 8'hF0; B = 8'h0F; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort S", S, 0);
    chk("abort Cout", Cout, 0);
    chk("abort busy", busy, 0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("abort Ovf", Ovf, 0);
`endif
    hold_s = '0; hold_c = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk); #1;
      if (done || busy) bad++;
    end
    chk("abort no done", bad, 0);

    // randomized regression against the reference
    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      r  = ref_add(ra, rb, rc);
      run_op(ra, rb, rc, -1, "rnd", r[W-1:0], r[W], r[W+1]);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
